// File: rtl/ps2_key_sequencer.sv
// Drains the ps2_keyboard scan-code FIFO and assembles E0/F0-prefixed byte
// sequences into key events, with typematic filtering, press counting and overflow latch.
module ps2_key_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_rel,
  output logic       key_held,
  output logic [8:0] held_code,
  output logic [7:0] press_count,
  output logic       ovf_err
);

  typedef enum logic [1:0] {IDLE, POP, SETTLE, EMIT} state_t;

  localparam logic [7:0]       PFX_EXT  = 8'hE0;
  localparam logic [7:0]       PFX_BRK  = 8'hF0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [7:0]       byte_q;
  logic             ext_q;
  logic             brk_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [8:0]       ev_key;

  assign ev_key = {ext_q, byte_q};

  // nextdata_n is registered and low only for the cycle spent in POP
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      byte_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      tmo_cnt     <= '0;
      nextdata_n  <= 1'b1;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_rel     <= 1'b0;
      key_held    <= 1'b0;
      held_code   <= 9'h000;
      press_count <= 8'h00;
      ovf_err     <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      nextdata_n <= 1'b1;
      case (state)
        IDLE: begin
          if (ready) begin
            byte_q     <= data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end else if (ext_q || brk_q) begin
            // A dangling prefix is dropped once the follow byte is overdue
            if (tmo_cnt == TMO_LAST) begin
              ext_q   <= 1'b0;
              brk_q   <= 1'b0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
        end
        POP: begin
          tmo_cnt <= '0;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (byte_q == PFX_EXT) begin
            ext_q <= 1'b1;
            state <= IDLE;
          end else if (byte_q == PFX_BRK) begin
            brk_q <= 1'b1;
            state <= IDLE;
          end else begin
            key_valid <= 1'b1;
            key_code  <= byte_q;
            key_ext   <= ext_q;
            key_rel   <= brk_q;
            state     <= EMIT;
            // Held-key tracking: repeats of the held key are not new presses
            if (!brk_q) begin
              if (!key_held || (held_code != ev_key)) begin
                key_held    <= 1'b1;
                held_code   <= ev_key;
                press_count <= press_count + 8'd1;
              end
            end else if (held_code == ev_key) begin
              key_held <= 1'b0;
            end
          end
        end
        EMIT: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (overflow) begin
        ovf_err <= 1'b1;
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
      end
    end
  end

endmodule
